// File: rtl/fc_l2_arb_pkg.sv
// Shared types and the round-robin pick helper for the FC L2 port arbiter.
package fc_l2_arb_pkg;

  localparam int unsigned N_REQ_DFLT = 5;
  localparam int unsigned ID_W       = $clog2(N_REQ_DFLT);

  // The pick helper works on a fixed-width view so any N_REQ up to MAX_REQ can use it.
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = 5;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], searching from ptr upward and wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= n) cand = cand - n;
      if ((i < n) && !res.valid && req[cand[IDX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_l2_arb_id_fifo.sv
// Register-based in-order ID FIFO: remembers which requester issued each granted
// transaction so the matching response can be routed back.
module fc_l2_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  // Status flags and qualified push/pop.
  always_comb begin
    full_o  = (cnt_q == CntW'(Depth));
    empty_o = (cnt_q == '0);
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
    head_o  = mem_q[rd_ptr_q];
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally modulo Depth; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM master port between the FC core and
// HWPE master ports, with in-order response routing through an ID FIFO.
module fc_l2_port_arbiter
  import fc_l2_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 5,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]    add_i,
  input  logic [N_REQ-1:0]               wen_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]    wdata_i,
  input  logic [N_REQ*BE_WIDTH-1:0]      be_i,
  output logic [N_REQ-1:0]               gnt_o,
  output logic [N_REQ-1:0]               r_valid_o,
  output logic [DATA_WIDTH-1:0]          r_rdata_o,
  output logic                           r_opc_o,
  output logic                           l2_req_o,
  output logic [ADDR_WIDTH-1:0]          l2_add_o,
  output logic                           l2_wen_o,
  output logic [DATA_WIDTH-1:0]          l2_wdata_o,
  output logic [BE_WIDTH-1:0]            l2_be_o,
  input  logic                           l2_gnt_i,
  input  logic                           l2_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          l2_r_rdata_i,
  input  logic                           l2_r_opc_i,
  output logic                           spurious_o
);

  localparam int unsigned IdW = $clog2(N_REQ);

  rr_pick_t       win;
  logic [IdW-1:0] win_id;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] fifo_head;
  logic           fifo_full, fifo_empty;
  logic           granted, pop;
  logic           spurious_q;

  // Winner selection, L2 request muxing and zero-latency grant/response routing.
  always_comb begin
    win        = rr_pick(MAX_REQ'(req_i), IDX_W'(rr_ptr_q), N_REQ);
    win_id     = IdW'(win.idx);
    l2_req_o   = (|req_i) & ~fifo_full & ~rst_i;
    granted    = l2_gnt_i & l2_req_o;
    pop        = l2_r_valid_i & ~fifo_empty;
    l2_add_o   = '0;
    l2_wen_o   = 1'b0;
    l2_wdata_o = '0;
    l2_be_o    = '0;
    if (win.valid) begin
      l2_add_o   = add_i[win_id*ADDR_WIDTH +: ADDR_WIDTH];
      l2_wen_o   = wen_i[win_id];
      l2_wdata_o = wdata_i[win_id*DATA_WIDTH +: DATA_WIDTH];
      l2_be_o    = be_i[win_id*BE_WIDTH +: BE_WIDTH];
    end
    gnt_o = '0;
    if (granted) gnt_o[win_id] = 1'b1;
    r_valid_o = '0;
    if (pop && !rst_i) r_valid_o[fifo_head] = 1'b1;
    r_rdata_o = l2_r_rdata_i;
    r_opc_o   = l2_r_opc_i;
    rr_ptr_d  = (win_id == IdW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    spurious_o = spurious_q;
  end

  // Round-robin pointer moves past the winner only on granted cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rr_ptr_q <= '0;
    else if (granted) rr_ptr_q <= rr_ptr_d;
  end

  // Sticky flag for a response that had no outstanding transaction to match.
  always_ff @(posedge clk_i) begin
    if (rst_i)                           spurious_q <= 1'b0;
    else if (l2_r_valid_i && fifo_empty) spurious_q <= 1'b1;
  end

  fc_l2_arb_id_fifo #(
    .Depth (MAX_OUTST),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (granted),
    .data_i  (win_id),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Directed self-checking bench for fc_l2_port_arbiter.
module tb_fc_l2_port_arbiter;

  localparam int N  = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] add_i;
  logic [N-1:0]    wen_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*BW-1:0] be_i;
  logic [N-1:0]    gnt_o, r_valid_o;
  logic [DW-1:0]   r_rdata_o;
  logic            r_opc_o, l2_req_o, l2_wen_o, spurious_o;
  logic [AW-1:0]   l2_add_o;
  logic [DW-1:0]   l2_wdata_o;
  logic [BW-1:0]   l2_be_o;
  logic            l2_gnt_i, l2_r_valid_i, l2_r_opc_i;
  logic [DW-1:0]   l2_r_rdata_i;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fc_l2_port_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .MAX_OUTST  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .add_i        (add_i),
    .wen_i        (wen_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .gnt_o        (gnt_o),
    .r_valid_o    (r_valid_o),
    .r_rdata_o    (r_rdata_o),
    .r_opc_o      (r_opc_o),
    .l2_req_o     (l2_req_o),
    .l2_add_o     (l2_add_o),
    .l2_wen_o     (l2_wen_o),
    .l2_wdata_o   (l2_wdata_o),
    .l2_be_o      (l2_be_o),
    .l2_gnt_i     (l2_gnt_i),
    .l2_r_valid_i (l2_r_valid_i),
    .l2_r_rdata_i (l2_r_rdata_i),
    .l2_r_opc_i   (l2_r_opc_i),
    .spurious_o   (spurious_o)
  );

  function automatic logic [31:0] addr_of(input int k);
    return 32'h1000 + 32'(k * 16);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock, then settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_w [8] = '{1, 4, 4, 1, 1, 4, 4, 1};
  int exp_g [8] = '{2, 0, 16, 0, 2, 0, 16, 0};

  initial begin
    rst_i        = 1'b1;
    req_i        = 5'b11111;
    wen_i        = 5'b01010;
    l2_gnt_i     = 1'b1;
    l2_r_valid_i = 1'b0;
    l2_r_rdata_i = '0;
    l2_r_opc_i   = 1'b0;
    for (int k = 0; k < N; k++) begin
      add_i[k*AW +: AW]   = addr_of(k);
      wdata_i[k*DW +: DW] = 32'hA000_0000 + 32'(k);
      be_i[k*BW +: BW]    = 4'(k + 1);
    end

    // Reset held for three edges with every requester active.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_gnt", gnt_o, 0);
      chk("rst_l2_req", l2_req_o, 0);
      chk("rst_r_valid", r_valid_o, 0);
      chk("rst_spurious", spurious_o, 0);
    end
    rst_i = 1'b0;

    // Round-robin with all requesters, 1-cycle L2 latency.
    for (int c = 0; c < 10; c++) begin
      l2_r_valid_i = (c > 0);
      l2_r_rdata_i = 32'h5000 + 32'(c);
      #1;
      chk("rr_gnt", gnt_o, 64'(1) << (c % 5));
      chk("rr_add", l2_add_o, addr_of(c % 5));
      if (c > 0) chk("rr_r_valid", r_valid_o, 64'(1) << ((c - 1) % 5));
      if (c == 2) begin
        chk("rr_wdata", l2_wdata_o, 32'hA000_0002);
        chk("rr_be", l2_be_o, 3);
        chk("rr_wen0", l2_wen_o, 0);
      end
      if (c == 3) begin
        chk("rr_wen1", l2_wen_o, 1);
        chk("rr_rdata", r_rdata_o, 32'h5003);
      end
      cyc();
    end
    req_i        = '0;
    l2_r_valid_i = 1'b1;
    #1;
    chk("rr_last_r_valid", r_valid_o, 5'b10000);
    chk("idle_l2_req", l2_req_o, 0);
    chk("idle_add_zero", l2_add_o, 0);
    cyc();

    // Fairness with grant gaps: requesters 1 and 4.
    req_i = 5'b10010;
    for (int s = 0; s < 8; s++) begin
      l2_gnt_i     = (s % 2 == 0);
      l2_r_valid_i = (s % 2 == 1);
      #1;
      chk("fair_gnt", gnt_o, 64'(exp_g[s]));
      chk("fair_add", l2_add_o, addr_of(exp_w[s]));
      if (s % 2 == 1) begin
        chk("fair_l2_req", l2_req_o, 1);
        chk("fair_r_valid", r_valid_o, 64'(exp_g[s-1]));
      end
      cyc();
    end

    // FIFO full: responses withheld.
    req_i        = 5'b00001;
    l2_gnt_i     = 1'b1;
    l2_r_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_fill_gnt", gnt_o, 1);
      cyc();
    end
    #1;
    chk("full_l2_req", l2_req_o, 0);
    chk("full_gnt", gnt_o, 0);
    cyc();
    l2_r_valid_i = 1'b1;
    #1;
    chk("full_pop_r_valid", r_valid_o, 1);
    chk("full_pop_gnt", gnt_o, 0);
    chk("full_pop_l2_req", l2_req_o, 0);
    cyc();
    l2_r_valid_i = 1'b0;
    #1;
    chk("full_reopen_gnt", gnt_o, 1);
    chk("full_reopen_l2_req", l2_req_o, 1);
    cyc();
    req_i        = '0;
    l2_r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_drain_r_valid", r_valid_o, 1);
      cyc();
    end
    l2_r_valid_i = 1'b0;
    #1;
    chk("drain_spurious", spurious_o, 0);

    // Push and pop in the same cycle with two outstanding.
    req_i = 5'b00100;
    #1;
    chk("pp_gnt2", gnt_o, 5'b00100);
    cyc();
    req_i = 5'b00010;
    #1;
    chk("pp_gnt1", gnt_o, 5'b00010);
    cyc();
    req_i        = 5'b01000;
    l2_r_valid_i = 1'b1;
    #1;
    chk("pp_gnt3", gnt_o, 5'b01000);
    chk("pp_r_valid_head", r_valid_o, 5'b00100);
    cyc();
    req_i = '0;
    #1;
    chk("pp_r_valid_1", r_valid_o, 5'b00010);
    cyc();
    #1;
    chk("pp_r_valid_tail3", r_valid_o, 5'b01000);
    cyc();
    l2_r_valid_i = 1'b0;
    #1;
    chk("pp_spurious", spurious_o, 0);

    // Spurious response with the FIFO empty.
    l2_r_valid_i = 1'b1;
    l2_r_rdata_i = 32'hDEAD_BEEF;
    l2_r_opc_i   = 1'b1;
    #1;
    chk("sp_r_valid", r_valid_o, 0);
    chk("sp_rdata", r_rdata_o, 32'hDEAD_BEEF);
    chk("sp_opc", r_opc_o, 1);
    chk("sp_not_yet", spurious_o, 0);
    cyc();
    l2_r_valid_i = 1'b0;
    l2_r_opc_i   = 1'b0;
    #1;
    chk("sp_set", spurious_o, 1);
    req_i = 5'b00001;
    cyc();
    req_i        = '0;
    l2_r_valid_i = 1'b1;
    #1;
    chk("sp_normal_r_valid", r_valid_o, 1);
    cyc();
    l2_r_valid_i = 1'b0;
    #1;
    chk("sp_sticky", spurious_o, 1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1;
    chk("sp_cleared", spurious_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
